uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that supersedes the fixed 8N1 transmitter. It supports a configurable data width (5-9 bits), optional even or odd parity, and 1 or 2 stop bits. A one-entry holding buffer with a ready/valid handshake allows back-to-back frames with zero idle cycles between them. It sits between the camera/FIFO readout logic and the board UART pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range is 2 or more.
DATA_BITS, 8, data bits per frame; legal values 5..9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
i_Tx_Dv  input  1  byte valid; accepted when i_Tx_Dv and o_Tx_Ready are both high at a clk edge
i_Tx_Byte  input  DATA_BITS  data word, sampled on acceptance
o_Tx_Ready  output  1  holding buffer empty; may accept a word
o_Tx_Active  output  1  a frame is on the line
o_Tx_Serial  output  1  serial line, idle high
o_Tx_Done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (asynchronous, rst = 1):
  - o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0.
  - Holding buffer cleared, so o_Tx_Ready = 1.
  - Bit counter, clock counter and state all return to IDLE.
  - i_Tx_Dv is ignored while rst = 1.
  - A reset mid-frame truncates the frame immediately; no Done pulse is generated.
- Handshake:
  - o_Tx_Ready = !buf_valid.
  - i_Tx_Dv while o_Tx_Ready = 0 is ignored; the word is dropped and the buffer is unchanged.
  - Accept and drain never coincide, because ready is low whenever the buffer is full.
- States: IDLE, START, DATA, PARITY, STOP.
  - One clock counter, 0..CLKS_PER_BIT-1; every state holds for exactly CLKS_PER_BIT cycles.
- IDLE:
  - When buf_valid = 1, load the shifter from the buffer at the next edge, clear buf_valid, and enter START.
  - At that same edge, o_Tx_Serial <= 0 and o_Tx_Active <= 1.
  - Timing: if a word is accepted at edge E0 with the FSM idle, the line falls at edge E1.
- START: drives 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Bits go out LSB first; bit index runs 0..DATA_BITS-1.
  - After the last bit, go to PARITY if PARITY != 0, otherwise STOP.
- PARITY:
  - Even mode: drive XOR of all DATA_BITS bits.
  - Odd mode: drive the inverse of that XOR.
  - Parity is computed from the latched shifter contents, never from i_Tx_Byte.
- STOP:
  - Drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final stop cycle's edge, pulse o_Tx_Done = 1 for one cycle.
  - If buf_valid = 1 at that edge: load the buffer, enter START, and drive o_Tx_Serial <= 0 at the same edge. There are zero idle cycles and o_Tx_Active stays 1.
  - Otherwise: go to IDLE and drop o_Tx_Active at the same edge.
- Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, measured falling edge to falling edge when frames run back-to-back.
- Widths:
  - Clock counter width is $clog2(CLKS_PER_BIT*2).
  - The counter never wraps inside a bit; it resets to 0 on every bit transition.
- Illegal parameters are rejected at elaboration with a $error: DATA_BITS outside 5..9, PARITY > 2, STOP_BITS outside 1..2, or CLKS_PER_BIT < 2.
- Unused: there is no flow control and no break generation.

Test Plan:
1. 8N1, CLKS_PER_BIT=4, send 0xA5 from idle -> line falls 1 cycle after acceptance. Bits are 0 | 1,0,1,0,0,1,0,1 | 1, each 4 cycles. Done pulses once, 40 cycles after the line fell. Active is high for exactly 40 cycles.
2. PARITY=1 then PARITY=2 (8 data, 1 stop, CLKS_PER_BIT=4), send 0x07 -> parity bit 1 (even) and 0 (odd). Frame is 44 cycles.
3. DATA_BITS=7, STOP_BITS=2, send 0x7F with upper bits ignored -> 7 ones, then the line is high for 8 cycles. Done at cycle 40.
4. Back-to-back: accept 0x55, then 0xAA while the first frame is in flight -> ready drops after each accept. The second start bit follows the first stop bit with zero idle cycles. Done pulses at cycles 40 and 80, and Active never drops in between.
5. Buffer full: during frame 1 with the buffer holding 0xAA, assert Dv with 0x3C -> ignored. Only 0x55 and 0xAA appear on the line.
6. Assert rst in the middle of data bit 3 -> o_Tx_Serial = 1 and Active = 0 asynchronously, no Done pulse, Ready = 1. A new word after release transmits a correct full frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5-9 data bits, optional parity, 1-2 stop bits) with a one-word holding buffer
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_Tx_Dv,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT * 2);
  localparam int BW = $clog2(DATA_BITS);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter set");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n, hold, hold_n;
  logic hold_v, hold_v_n, ser, ser_n, act, act_n, done, done_n, load;
  logic bit_end, stop_end, par;
  assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
  assign stop_end = cnt == CW'(STOP_BITS * CLKS_PER_BIT - 1);
  assign par      = (^sh) ^ (PARITY == 2);
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    sh_n     = sh;
    hold_n   = hold;
    hold_v_n = hold_v;
    ser_n    = ser;
    act_n    = act;
    done_n   = 1'b0;
    load     = 1'b0;
    if (i_Tx_Dv && !hold_v) begin
      hold_v_n = 1'b1;
      hold_n   = i_Tx_Byte;
    end
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        load  = hold_v;
      end
      S_START: if (bit_end) begin
        state_n = S_DATA;
        cnt_n   = '0;
        idx_n   = '0;
        ser_n   = sh[0];
      end
      S_DATA: if (bit_end) begin
        cnt_n = '0;
        if (idx == BW'(DATA_BITS - 1)) begin
          state_n = PARITY != 0 ? S_PAR : S_STOP;
          ser_n   = PARITY != 0 ? par : 1'b1;
        end else begin
          idx_n = idx + 1'b1;
          ser_n = sh[idx_n];
        end
      end
      S_PAR: if (bit_end) begin
        state_n = S_STOP;
        cnt_n   = '0;
        ser_n   = 1'b1;
      end
      S_STOP: if (stop_end) begin
        cnt_n   = '0;
        done_n  = 1'b1;
        load    = hold_v;
        state_n = S_IDLE;
        act_n   = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
    // a pending word starts its frame on the same edge, so back-to-back frames have no idle gap
    if (load) begin
      state_n  = S_START;
      sh_n     = hold;
      hold_v_n = 1'b0;
      ser_n    = 1'b0;
      act_n    = 1'b1;
      cnt_n    = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
      ser    <= 1'b1;
      act    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      hold   <= hold_n;
      hold_v <= hold_v_n;
      ser    <= ser_n;
      act    <= act_n;
      done   <= done_n;
    end
  end
  assign o_Tx_Ready  = !hold_v;
  assign o_Tx_Active = act;
  assign o_Tx_Serial = ser;
  assign o_Tx_Done   = done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitter configurations checked against a frame-position reference model and fixed frame vectors
module tb_uart_tx_cfg;
  localparam int CPB = 4;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 1, 2, 0};
  localparam int SB [4] = '{1, 1, 1, 2};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] dv = '0;
  logic [8:0] byte_in [4];
  logic [3:0] ser, act, dn, rdy;
  int total = 0;
  int bad = 0;
  int pos [4];
  logic pv [4];
  logic dm [4];
  logic [8:0] pw [4];
  logic [8:0] cw [4];
  typedef struct {int c; logic [8:0] w; logic [19:0] f; int nb;} vec_t;
  vec_t tbl [8];
  logic [19:0] b2b_bits;
  int d1, d2, dcnt, acnt, idle_bad;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB[g]), .PARITY(PM[g]), .STOP_BITS(SB[g])) u (
      .clk(clk), .rst(rst), .i_Tx_Dv(dv[g]), .i_Tx_Byte(byte_in[g][DB[g]-1:0]),
      .o_Tx_Ready(rdy[g]), .o_Tx_Active(act[g]), .o_Tx_Serial(ser[g]), .o_Tx_Done(dn[g]));
  end
  function automatic int flen(int i);
    return CPB * (1 + DB[i] + (PM[i] != 0 ? 1 : 0) + SB[i]);
  endfunction
  // expected line level at cycle p of a frame carrying word w
  function automatic logic lvl(int i, int p, logic [8:0] w);
    int b;
    logic [8:0] m, s;
    b = p / CPB;
    m = w & 9'((1 << DB[i]) - 1);
    s = m >> (b - 1);
    if (b == 0) return 1'b0;
    if (b <= DB[i]) return s[0];
    if (PM[i] != 0 && b == DB[i] + 1) return (^m) ^ (PM[i] == 2);
    return 1'b1;
  endfunction
  function automatic logic ldm(int i);
    return (pos[i] < 0 || pos[i] == flen(i) - 1) && pv[i];
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pos[i] <= -1;
        pv[i]  <= 1'b0;
        dm[i]  <= 1'b0;
        pw[i]  <= '0;
        cw[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        pos[i] <= (pos[i] >= 0 && pos[i] < flen(i) - 1) ? pos[i] + 1 : (pv[i] ? 0 : -1);
        dm[i]  <= pos[i] == flen(i) - 1;
        if (ldm(i)) cw[i] <= pw[i];
        pv[i]  <= (dv[i] && !pv[i]) ? 1'b1 : (ldm(i) ? 1'b0 : pv[i]);
        if (dv[i] && !pv[i]) pw[i] <= byte_in[i];
      end
    end
  end
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick();
    logic [3:0] got, exp;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      got = {ser[i], act[i], dn[i], rdy[i]};
      exp = {pos[i] < 0 ? 1'b1 : lvl(i, pos[i], cw[i]), pos[i] >= 0, dm[i], !pv[i]};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL model[%0d] at %0t: ser/act/done/rdy got %b expected %b", i, $time, got, exp);
      end
    end
  endtask
  task automatic send_check(int c, logic [8:0] w, logic [19:0] f, int nb);
    logic [19:0] got;
    int dn_at, act_n, len;
    got = '0;
    dn_at = -1;
    act_n = 0;
    len = CPB * nb;
    for (int k = 0; k < 200 && act[c]; k++) tick();
    chk("idle_before_send", 32'(act[c]), 32'd0);
    dv[c] = 1'b1;
    byte_in[c] = w;
    tick();
    dv[c] = 1'b0;
    chk("ready_low_after_accept", 32'(rdy[c]), 32'd0);
    for (int n = 1; n <= len + 1; n++) begin
      tick();
      if ((n - 1) % CPB == CPB / 2 && (n - 1) / CPB < nb) got[(n - 1) / CPB] = ser[c];
      if (dn[c] && dn_at < 0) dn_at = n;
      if (act[c]) act_n++;
    end
    chk("frame_bits", 32'(got), 32'(f));
    chk("done_cycle", dn_at, len + 1);
    chk("active_cycles", act_n, len);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{0, 9'h0A5, 20'h0034A, 10};
    tbl[1] = '{0, 9'h000, 20'h00200, 10};
    tbl[2] = '{1, 9'h007, 20'h0060E, 11};
    tbl[3] = '{1, 9'h000, 20'h00400, 11};
    tbl[4] = '{2, 9'h007, 20'h0040E, 11};
    tbl[5] = '{2, 9'h0FF, 20'h007FE, 11};
    tbl[6] = '{3, 9'h0FF, 20'h003FE, 10};
    tbl[7] = '{3, 9'h02A, 20'h00354, 10};
    for (int i = 0; i < 4; i++) byte_in[i] = '0;
    repeat (3) tick();
    chk("reset_serial", 32'(ser), 32'hF);
    chk("reset_active", 32'(act), 32'h0);
    chk("reset_done", 32'(dn), 32'h0);
    chk("reset_ready", 32'(rdy), 32'hF);
    rst = 1'b0;
    tick();
    for (int t = 0; t < 8; t++) send_check(tbl[t].c, tbl[t].w, tbl[t].f, tbl[t].nb);
    // back-to-back frames plus a word offered while the buffer is full
    b2b_bits = '0;
    d1 = -1;
    d2 = -1;
    dcnt = 0;
    acnt = 0;
    idle_bad = 0;
    dv[0] = 1'b1;
    byte_in[0] = 9'h055;
    tick();
    dv[0] = 1'b0;
    chk("b2b_ready_first", 32'(rdy[0]), 32'd0);
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (n == 4) begin dv[0] = 1'b1; byte_in[0] = 9'h0AA; end
      if (n == 5) begin dv[0] = 1'b0; chk("b2b_ready_second", 32'(rdy[0]), 32'd0); end
      if (n == 10) begin dv[0] = 1'b1; byte_in[0] = 9'h03C; end
      if (n == 12) dv[0] = 1'b0;
      if (n <= 80 && (n - 1) % CPB == CPB / 2) b2b_bits[(n - 1) / CPB] = ser[0];
      if (dn[0]) begin
        dcnt++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n <= 80 && act[0]) acnt++;
      if (n > 81 && (ser[0] !== 1'b1 || act[0] !== 1'b0)) idle_bad++;
    end
    chk("b2b_bits", 32'(b2b_bits), 32'h000D52AA);
    chk("b2b_done1", d1, 41);
    chk("b2b_done2", d2, 81);
    chk("b2b_done_count", dcnt, 2);
    chk("b2b_active", acnt, 80);
    chk("b2b_idle_after", idle_bad, 0);
    // reset in the middle of data bit 3
    dv[0] = 1'b1;
    byte_in[0] = 9'h0A5;
    tick();
    dv[0] = 1'b0;
    repeat (18) tick();
    chk("pre_reset_serial", 32'(ser[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_serial", 32'(ser[0]), 32'd1);
    chk("rst_active", 32'(act[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_done", 32'(dn[0]), 32'd0);
    dv[0] = 1'b1;
    byte_in[0] = 9'h1FF;
    repeat (3) begin
      tick();
      chk("rst_no_done", 32'(dn[0]), 32'd0);
    end
    dv[0] = 1'b0;
    rst = 1'b0;
    chk("rst_ready_after", 32'(rdy[0]), 32'd1);
    send_check(0, 9'h03C, 20'h00278, 10);
    repeat (1500) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        dv[i] = $urandom_range(0, 2) == 0;
        byte_in[i] = 9'($urandom);
      end
    end
    dv = '0;
    repeat (200) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
